// File: rtl/dragonfang_pkg.sv
// Shared types for the dragonfang vector pipeline: operand packets as they
// leave the register file, the issuing micro-op, and the bundle that travels
// from the register read stage to vector execute.
package dragonfang_pkg;

    // Vector register length in bits and physical register tag width.
    localparam int VLEN       = 32;
    localparam int TAG_LENGTH = 6;

    // Element width selector carried by every micro-op.
    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } vsew_t;

    // One operand as read from (or written to) the register file.
    typedef struct packed {
        logic [TAG_LENGTH-1:0] tag;
        logic [VLEN-1:0]       data;
    } data_packet_t;

    // Micro-op issued alongside its operands.
    typedef struct packed {
        logic [5:0] opcode;
        logic       vm;
        vsew_t      sew;
        logic [7:0] vl;
    } vector_uop_t;

    // Everything execute needs for one instruction.
    typedef struct packed {
        vector_uop_t  uop;
        data_packet_t v0;
        data_packet_t vs1;
        data_packet_t vs2;
        data_packet_t vd;
    } operand_bundle_t;

endpackage

// File: rtl/vector_operand_buffer_snoop.sv
// Write-back snoop for a single operand slot. The register file returns the
// value from before a same-cycle write, so any operand whose tag matches the
// write-back tag takes the write-back data instead. The tag itself is passed
// through untouched.
module operand_snoop
    import dragonfang_pkg::*;
#(
    parameter int DATA_WIDTH = VLEN,
    parameter int TAG_WIDTH  = TAG_LENGTH
) (
    input  data_packet_t i_packet,
    input  logic         write_back_valid,
    input  data_packet_t write_back_packet,
    output data_packet_t o_packet
);

    logic [TAG_WIDTH-1:0]  w_op_tag;
    logic [TAG_WIDTH-1:0]  w_wb_tag;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_hit;

    assign w_op_tag  = i_packet.tag;
    assign w_wb_tag  = write_back_packet.tag;
    assign w_wb_data = write_back_packet.data;
    assign w_hit     = write_back_valid && (w_op_tag == w_wb_tag);

    // Replace the data field on a tag hit, keep everything else.
    always_comb begin
        o_packet = i_packet;
        if (w_hit) begin
            o_packet.data = w_wb_data;
        end
    end

endmodule

// File: rtl/vector_operand_buffer.sv
// Operand FIFO between vector register read and vector execute. Holds up to
// DEPTH operand bundles, keeps every stored operand coherent with write-back
// (also while execute is stalling), and hands out one bundle per cycle over a
// valid/ready handshake. Outputs come straight from the head entry register;
// a bundle pushed in one cycle is visible the next cycle, never the same one.
module vector_operand_buffer
    import dragonfang_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = VLEN,
    parameter int TAG_WIDTH  = TAG_LENGTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  vector_uop_t                in_uop,
    input  data_packet_t               v0_packet,
    input  data_packet_t               vs1_packet,
    input  data_packet_t               vs2_packet,
    input  data_packet_t               vd_packet,
    input  logic                       write_back_valid,
    input  data_packet_t               write_back_packet,
    output logic                       out_valid,
    input  logic                       out_ready,
    output vector_uop_t                out_uop,
    output data_packet_t               out_v0,
    output data_packet_t               out_vs1,
    output data_packet_t               out_vs2,
    output data_packet_t               out_vd,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // FIFO storage and control state.
    operand_bundle_t  r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Snooped view of every stored entry and of the incoming bundle.
    data_packet_t     w_ent_v0  [DEPTH];
    data_packet_t     w_ent_vs1 [DEPTH];
    data_packet_t     w_ent_vs2 [DEPTH];
    data_packet_t     w_ent_vd  [DEPTH];
    operand_bundle_t  w_mem_snooped [DEPTH];
    data_packet_t     w_in_v0;
    data_packet_t     w_in_vs1;
    data_packet_t     w_in_vs2;
    data_packet_t     w_in_vd;
    operand_bundle_t  w_in_snooped;

    operand_bundle_t  w_head;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on the registered count, so a pop in the same cycle
    // cannot open a slot for a push while full.
    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = r_valid[r_rd_ptr];
    assign occupancy = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    assign w_head  = r_mem[r_rd_ptr];
    assign out_uop = w_head.uop;
    assign out_v0  = w_head.v0;
    assign out_vs1 = w_head.vs1;
    assign out_vs2 = w_head.vs2;
    assign out_vd  = w_head.vd;

    // One snoop per operand of every stored entry.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_snoop_v0 (
            .i_packet          (r_mem[g].v0),
            .write_back_valid  (write_back_valid),
            .write_back_packet (write_back_packet),
            .o_packet          (w_ent_v0[g])
        );
        operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_snoop_vs1 (
            .i_packet          (r_mem[g].vs1),
            .write_back_valid  (write_back_valid),
            .write_back_packet (write_back_packet),
            .o_packet          (w_ent_vs1[g])
        );
        operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_snoop_vs2 (
            .i_packet          (r_mem[g].vs2),
            .write_back_valid  (write_back_valid),
            .write_back_packet (write_back_packet),
            .o_packet          (w_ent_vs2[g])
        );
        operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_snoop_vd (
            .i_packet          (r_mem[g].vd),
            .write_back_valid  (write_back_valid),
            .write_back_packet (write_back_packet),
            .o_packet          (w_ent_vd[g])
        );

        assign w_mem_snooped[g] = '{
            uop: r_mem[g].uop,
            v0:  w_ent_v0[g],
            vs1: w_ent_vs1[g],
            vs2: w_ent_vs2[g],
            vd:  w_ent_vd[g]
        };
    end

    // The bundle being pushed sees the same write-back as stored entries.
    operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_in_snoop_v0 (
        .i_packet          (v0_packet),
        .write_back_valid  (write_back_valid),
        .write_back_packet (write_back_packet),
        .o_packet          (w_in_v0)
    );
    operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_in_snoop_vs1 (
        .i_packet          (vs1_packet),
        .write_back_valid  (write_back_valid),
        .write_back_packet (write_back_packet),
        .o_packet          (w_in_vs1)
    );
    operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_in_snoop_vs2 (
        .i_packet          (vs2_packet),
        .write_back_valid  (write_back_valid),
        .write_back_packet (write_back_packet),
        .o_packet          (w_in_vs2)
    );
    operand_snoop #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_in_snoop_vd (
        .i_packet          (vd_packet),
        .write_back_valid  (write_back_valid),
        .write_back_packet (write_back_packet),
        .o_packet          (w_in_vd)
    );

    assign w_in_snooped = '{
        uop: in_uop,
        v0:  w_in_v0,
        vs1: w_in_vs1,
        vs2: w_in_vs2,
        vd:  w_in_vd
    };

    // Pointers, count and per-entry valid bits; flush clears them ahead of push/pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // A push always lands in a free slot, so it never collides with the popped head.
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: snoop-refresh live entries, write the pushed bundle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush) begin
            // The entry leaving this cycle is freed, so its refresh is skipped.
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && !(w_pop && (r_rd_ptr == PTR_W'(i)))) begin
                    r_mem[i] <= w_mem_snooped[i];
                end
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_snooped;
            end
        end
    end

endmodule

// File: tb/tb_vector_operand_buffer.sv
// Bench for vector_operand_buffer: directed scenarios followed by random
// traffic, every cycle compared against a queue-based model of the buffer.
module tb_vector_operand_buffer;
    import dragonfang_pkg::*;

    localparam int DEPTH = 2;
    localparam int UW    = $bits(vector_uop_t);

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    vector_uop_t  in_uop = '0;
    data_packet_t v0_packet = '0;
    data_packet_t vs1_packet = '0;
    data_packet_t vs2_packet = '0;
    data_packet_t vd_packet = '0;
    logic         write_back_valid = 1'b0;
    data_packet_t write_back_packet = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    vector_uop_t  out_uop;
    data_packet_t out_v0;
    data_packet_t out_vs1;
    data_packet_t out_vs2;
    data_packet_t out_vd;
    logic [$clog2(DEPTH):0] occupancy;

    int checks = 0;
    int errors = 0;

    operand_bundle_t q[$];

    vector_operand_buffer #(.DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_uop            (in_uop),
        .v0_packet         (v0_packet),
        .vs1_packet        (vs1_packet),
        .vs2_packet        (vs2_packet),
        .vd_packet         (vd_packet),
        .write_back_valid  (write_back_valid),
        .write_back_packet (write_back_packet),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_uop           (out_uop),
        .out_v0            (out_v0),
        .out_vs1           (out_vs1),
        .out_vs2           (out_vs2),
        .out_vd            (out_vd),
        .occupancy         (occupancy)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic data_packet_t mk(input int tag, input logic [VLEN-1:0] data);
        data_packet_t p;
        p.tag  = TAG_LENGTH'(tag);
        p.data = data;
        return p;
    endfunction

    // A packet takes the write-back data when its tag matches a live write-back.
    function automatic data_packet_t ref_snoop(input data_packet_t p);
        data_packet_t r;
        r = p;
        if (write_back_valid && (p.tag == write_back_packet.tag)) r.data = write_back_packet.data;
        return r;
    endfunction

    function automatic operand_bundle_t ref_snoop_bundle(input operand_bundle_t b);
        operand_bundle_t r;
        r     = b;
        r.v0  = ref_snoop(b.v0);
        r.vs1 = ref_snoop(b.vs1);
        r.vs2 = ref_snoop(b.vs2);
        r.vd  = ref_snoop(b.vd);
        return r;
    endfunction

    task automatic drive_bundle(input int t0, input int t1, input int t2, input int t3);
        in_uop     = vector_uop_t'(UW'($urandom));
        v0_packet  = mk(t0, VLEN'($urandom));
        vs1_packet = mk(t1, VLEN'($urandom));
        vs2_packet = mk(t2, VLEN'($urandom));
        vd_packet  = mk(t3, VLEN'($urandom));
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out_valid"}, out_valid, (q.size() > 0));
        chk({tag, "_in_ready"}, in_ready, (q.size() < DEPTH));
        chk({tag, "_occupancy"}, occupancy, q.size());
        if (q.size() > 0) chk({tag, "_head"}, {out_uop, out_v0, out_vs1, out_vs2, out_vd}, q[0]);
    endtask

    // Advance the model by one clock using the inputs currently driven, then
    // let the DUT clock and compare shortly after the edge.
    task automatic cycle(input string tag);
        bit do_push;
        bit do_pop;
        operand_bundle_t inb;
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = out_ready && (q.size() > 0);
        if (flush) begin
            q.delete();
        end else begin
            for (int k = (do_pop ? 1 : 0); k < q.size(); k++) q[k] = ref_snoop_bundle(q[k]);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                inb = '{uop: in_uop, v0: v0_packet, vs1: vs1_packet, vs2: vs2_packet, vd: vd_packet};
                q.push_back(ref_snoop_bundle(inb));
            end
        end
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    initial begin
        data_packet_t keep_v0, keep_vs1, keep_vs2, keep_vd;

        // Reset asserted from time zero.
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_head_zero", {out_uop, out_v0, out_vs1, out_vs2, out_vd}, '0);
        @(negedge clock);
        reset_n = 1'b1;

        // Streaming with execute always ready.
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            drive_bundle(k, k, k, k);
            cycle("stream");
            chk("stream_order", out_vs1.tag, k);
            chk("stream_occ_le1", (occupancy <= 1), 1'b1);
        end
        in_valid = 1'b0;
        cycle("stream_drain");

        // Backpressure with a third push while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_bundle(10, 10, 10, 10);
        cycle("full_a");
        drive_bundle(11, 11, 11, 11);
        cycle("full_b");
        chk("full_in_ready_low", in_ready, 1'b0);
        drive_bundle(12, 12, 12, 12);
        cycle("full_c");
        chk("full_occ", occupancy, 2);
        chk("full_head_first", out_vs1.tag, 10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle("full_pop1");
        chk("full_head_second", out_vs1.tag, 11);
        cycle("full_pop2");
        chk("full_empty", out_valid, 1'b0);

        // Write-back into a stalled head entry.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_bundle(1, 2, 5, 3);
        keep_v0 = v0_packet; keep_vs1 = vs1_packet; keep_vd = vd_packet;
        cycle("stall_push");
        in_valid          = 1'b0;
        write_back_valid  = 1'b1;
        write_back_packet = mk(5, 32'h0000_A5A5);
        cycle("stall_snoop");
        chk("stall_vs2_data", out_vs2.data, 32'h0000_A5A5);
        chk("stall_vs2_tag", out_vs2.tag, 5);
        chk("stall_v0_same", out_v0, keep_v0);
        chk("stall_vs1_same", out_vs1, keep_vs1);
        chk("stall_vd_same", out_vd, keep_vd);
        write_back_valid = 1'b0;
        out_ready        = 1'b1;
        cycle("stall_drain");

        // Write-back hitting the bundle as it is pushed.
        out_ready         = 1'b0;
        in_valid          = 1'b1;
        drive_bundle(1, 7, 2, 7);
        keep_vs2          = vs2_packet;
        write_back_valid  = 1'b1;
        write_back_packet = mk(7, 32'h0000_1234);
        cycle("push_snoop");
        chk("push_snoop_vs1", out_vs1.data, 32'h0000_1234);
        chk("push_snoop_vd", out_vd.data, 32'h0000_1234);
        chk("push_snoop_vs2_same", out_vs2, keep_vs2);
        write_back_valid = 1'b0;
        in_valid         = 1'b0;
        out_ready        = 1'b1;
        cycle("push_snoop_drain");

        // Flush while full with a push and pop offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_bundle(20, 20, 20, 20);
        cycle("flush_fill_a");
        drive_bundle(21, 21, 21, 21);
        cycle("flush_fill_b");
        drive_bundle(22, 22, 22, 22);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle("flush_full");
        chk("flush_full_valid", out_valid, 1'b0);
        chk("flush_full_occ", occupancy, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle("flush_full_after");
        chk("flush_full_nodata", out_valid, 1'b0);

        // Flush with one entry, where the push would otherwise be accepted.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_bundle(23, 23, 23, 23);
        cycle("flush_one_fill");
        drive_bundle(24, 24, 24, 24);
        flush = 1'b1;
        cycle("flush_one");
        chk("flush_one_occ", occupancy, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle("flush_one_after");
        chk("flush_one_nodata", out_valid, 1'b0);

        // Asynchronous reset with two entries held.
        in_valid = 1'b1;
        drive_bundle(30, 30, 30, 30);
        cycle("arst_fill_a");
        drive_bundle(31, 31, 31, 31);
        cycle("arst_fill_b");
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_occupancy", occupancy, 0);
        chk("arst_head_zero", {out_uop, out_v0, out_vs1, out_vs2, out_vd}, '0);
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;

        // Random traffic with a small tag space so snoop hits are frequent.
        for (int n = 0; n < 400; n++) begin
            in_valid          = ($urandom_range(0, 3) != 0);
            out_ready         = ($urandom_range(0, 2) != 0);
            flush             = ($urandom_range(0, 31) == 0);
            write_back_valid  = ($urandom_range(0, 1) == 1);
            write_back_packet = mk($urandom_range(0, 7), VLEN'($urandom));
            drive_bundle($urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 7));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
